// File: rtl/demux_stream_1xn.sv
// demux_stream_1xn
// Registered 1-to-N stream demultiplexer with valid/ready handshakes.
// Each output channel owns a one-entry register, so a stalled consumer only
// blocks beats addressed to its own channel. Routing is either per-beat
// addressed (MODE=0, s_sel) or round-robin (MODE=1, internal rr_ptr).
// Out-of-range addressed beats are consumed, dropped and counted.

module demux_stream_1xn #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 8,
    parameter int MODE   = 0,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_W-1:0]          s_data,
    input  logic [SEL_W-1:0]           s_sel,
    output logic [NUM_CH-1:0]          m_valid,
    input  logic [NUM_CH-1:0]          m_ready,
    output logic [NUM_CH*DATA_W-1:0]   m_data,
    output logic [SEL_W-1:0]           rr_ptr,
    output logic                       err_sel,
    output logic [7:0]                 drop_cnt
);

    // Channel count widened by one bit so the range compare never truncates.
    localparam logic [SEL_W:0]   NUM_CH_W = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);
    localparam logic [7:0]       DROP_MAX = 8'hFF;

    logic [SEL_W-1:0]          tgt_s;
    logic                      in_range_s;
    logic [NUM_CH-1:0]         free_s;
    logic [NUM_CH-1:0]         hit_s;
    logic [NUM_CH-1:0]         load_s;
    logic                      s_ready_s;
    logic                      accept_s;
    logic                      drop_s;

    logic [NUM_CH-1:0]         m_valid_r;
    logic [NUM_CH*DATA_W-1:0]  m_data_r;
    logic [SEL_W-1:0]          rr_ptr_r;
    logic                      err_sel_r;
    logic [7:0]                drop_cnt_r;

    // Select the target channel: s_sel when addressed, rotating pointer otherwise.
    always_comb begin
        tgt_s = s_sel;
        if (MODE == 1) begin
            tgt_s = rr_ptr_r;
        end else begin
            tgt_s = s_sel;
        end
    end

    assign in_range_s = ({1'b0, tgt_s} < NUM_CH_W);

    // Per-channel free flag (empty, or draining this cycle) and target decode.
    always_comb begin
        free_s = {NUM_CH{1'b0}};
        hit_s  = {NUM_CH{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            free_s[k] = ~m_valid_r[k] | m_ready[k];
            hit_s[k]  = (tgt_s == SEL_W'(k));
        end
    end

    // Handshake: out-of-range beats are always taken so they can be dropped.
    always_comb begin
        s_ready_s = 1'b1;
        if (in_range_s) begin
            s_ready_s = |(hit_s & free_s);
        end else begin
            s_ready_s = 1'b1;
        end
    end

    assign accept_s = s_valid & s_ready_s;
    assign drop_s   = accept_s & ~in_range_s;

    // Load strobes go only to the addressed channel on an in-range accept.
    always_comb begin
        load_s = {NUM_CH{1'b0}};
        if (accept_s && in_range_s) begin
            load_s = hit_s;
        end else begin
            load_s = {NUM_CH{1'b0}};
        end
    end

    // Channel registers: load wins over drain, stall holds valid and data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_r <= {NUM_CH{1'b0}};
            m_data_r  <= {(NUM_CH*DATA_W){1'b0}};
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (load_s[k]) begin
                    m_valid_r[k]                   <= 1'b1;
                    m_data_r[k*DATA_W +: DATA_W]   <= s_data;
                end else if (m_ready[k]) begin
                    m_valid_r[k]                   <= 1'b0;
                end else begin
                    m_valid_r[k]                   <= m_valid_r[k];
                end
            end
        end
    end

    // Round-robin pointer advances only on an accept and wraps at the last channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= {SEL_W{1'b0}};
        end else if (MODE != 1) begin
            rr_ptr_r <= {SEL_W{1'b0}};
        end else if (accept_s) begin
            if (rr_ptr_r == LAST_CH) begin
                rr_ptr_r <= {SEL_W{1'b0}};
            end else begin
                rr_ptr_r <= rr_ptr_r + SEL_W'(1);
            end
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Drop reporting: one-cycle error pulse and a saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel_r  <= 1'b0;
            drop_cnt_r <= 8'd0;
        end else begin
            err_sel_r <= drop_s;
            if (drop_s && (drop_cnt_r != DROP_MAX)) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    assign s_ready  = s_ready_s;
    assign m_valid  = m_valid_r;
    assign m_data   = m_data_r;
    assign rr_ptr   = rr_ptr_r;
    assign err_sel  = err_sel_r;
    assign drop_cnt = drop_cnt_r;

    demux_stream_1xn_chk #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .MODE   (MODE)
    ) u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_valid  (m_valid_r),
        .m_ready  (m_ready),
        .m_data   (m_data_r),
        .rr_ptr   (rr_ptr_r),
        .drop_cnt (drop_cnt_r)
    );

endmodule

// Invariants of the demultiplexer, kept apart from the datapath.
module demux_stream_1xn_chk #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 8,
    parameter int MODE   = 0,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input logic                      clk,
    input logic                      rst_n,
    input logic [NUM_CH-1:0]         m_valid,
    input logic [NUM_CH-1:0]         m_ready,
    input logic [NUM_CH*DATA_W-1:0]  m_data,
    input logic [SEL_W-1:0]          rr_ptr,
    input logic [7:0]                drop_cnt
);

    localparam logic [SEL_W:0] NUM_CH_W = (SEL_W+1)'(NUM_CH);

    a_rr_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, rr_ptr} < NUM_CH_W));

    a_rr_zero_addr: assert property (@(posedge clk) disable iff (!rst_n)
        ((MODE == 1) || (rr_ptr == {SEL_W{1'b0}})));

    a_drop_sat: assert property (@(posedge clk) disable iff (!rst_n)
        (drop_cnt == 8'hFF) |=> (drop_cnt == 8'hFF));

    for (genvar k = 0; k < NUM_CH; k++) begin : g_hold
        a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
            (m_valid[k] && !m_ready[k]) |=>
            (m_valid[k] && $stable(m_data[k*DATA_W +: DATA_W])));
    end

endmodule

// File: tb/tb_demux_stream_1xn.sv
// Directed self-checking bench for demux_stream_1xn.
// Three instances: addressed 8 channels, round-robin 3 channels,
// addressed 5 channels (non power of two, for out-of-range drops).

module tb_demux_stream_1xn;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // Instance A: MODE=0, NUM_CH=8
    logic        sv_a, sr_a, es_a;
    logic [7:0]  sd_a, mv_a, mr_a, dc_a;
    logic [2:0]  ss_a, rp_a;
    logic [63:0] md_a;

    // Instance B: MODE=1, NUM_CH=3
    logic        sv_b, sr_b, es_b;
    logic [7:0]  sd_b, dc_b;
    logic [1:0]  ss_b, rp_b;
    logic [2:0]  mv_b, mr_b;
    logic [23:0] md_b;

    // Instance C: MODE=0, NUM_CH=5
    logic        sv_c, sr_c, es_c;
    logic [7:0]  sd_c, dc_c;
    logic [2:0]  ss_c, rp_c;
    logic [4:0]  mv_c, mr_c;
    logic [39:0] md_c;

    int n_checks = 0;
    int n_errors = 0;

    demux_stream_1xn #(.DATA_W(8), .NUM_CH(8), .MODE(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .s_valid(sv_a), .s_ready(sr_a), .s_data(sd_a),
        .s_sel(ss_a), .m_valid(mv_a), .m_ready(mr_a), .m_data(md_a),
        .rr_ptr(rp_a), .err_sel(es_a), .drop_cnt(dc_a)
    );

    demux_stream_1xn #(.DATA_W(8), .NUM_CH(3), .MODE(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .s_valid(sv_b), .s_ready(sr_b), .s_data(sd_b),
        .s_sel(ss_b), .m_valid(mv_b), .m_ready(mr_b), .m_data(md_b),
        .rr_ptr(rp_b), .err_sel(es_b), .drop_cnt(dc_b)
    );

    demux_stream_1xn #(.DATA_W(8), .NUM_CH(5), .MODE(0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .s_valid(sv_c), .s_ready(sr_c), .s_data(sd_c),
        .s_sel(ss_c), .m_valid(mv_c), .m_ready(mr_c), .m_data(md_c),
        .rr_ptr(rp_c), .err_sel(es_c), .drop_cnt(dc_c)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        sv_a = 1'b0; sd_a = 8'h00; ss_a = 3'd0; mr_a = 8'h00;
        sv_b = 1'b0; sd_b = 8'h00; ss_b = 2'd0; mr_b = 3'b000;
        sv_c = 1'b0; sd_c = 8'h00; ss_c = 3'd0; mr_c = 5'b00000;
        tick;
        tick;

        // Reset state
        check_val("rst_mv_a", mv_a, 32'h0);
        check_val("rst_md_a_or", {31'd0, |md_a}, 32'h0);
        check_val("rst_rp_b", rp_b, 32'h0);
        check_val("rst_es_c", es_c, 32'h0);
        check_val("rst_dc_c", dc_c, 32'h0);
        rst_n = 1'b1;
        tick;

        // Addressed streaming, all consumers ready
        mr_a = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            sv_a = 1'b1; ss_a = 3'(k); sd_a = 8'hA0 + 8'(k);
            #1;
            check_val($sformatf("strm_sr_%0d", k), sr_a, 32'h1);
            tick;
            check_val($sformatf("strm_mv_%0d", k), mv_a, 32'(8'h01 << k));
            check_val($sformatf("strm_md_%0d", k), md_a[k*8 +: 8], 32'(8'hA0 + 8'(k)));
        end
        sv_a = 1'b0;
        tick;
        check_val("strm_idle_mv", mv_a, 32'h0);
        check_val("strm_rp_a", rp_a, 32'h0);

        // Backpressure isolation on channel 3
        mr_a = 8'hF7;
        sv_a = 1'b1; ss_a = 3'd3; sd_a = 8'h11;
        #1;
        check_val("bp_sr_first", sr_a, 32'h1);
        tick;
        check_val("bp_mv3_first", mv_a, 32'h08);
        check_val("bp_md3_first", md_a[24 +: 8], 32'h11);
        sd_a = 8'h22;
        #1;
        check_val("bp_sr_blocked", sr_a, 32'h0);
        tick;
        check_val("bp_mv3_hold", mv_a, 32'h08);
        check_val("bp_md3_hold", md_a[24 +: 8], 32'h11);
        ss_a = 3'd1; sd_a = 8'h33;
        #1;
        check_val("bp_sr_ch1", sr_a, 32'h1);
        tick;
        check_val("bp_mv_ch1", mv_a, 32'h0A);
        check_val("bp_md1", md_a[8 +: 8], 32'h33);
        ss_a = 3'd3; sd_a = 8'h22; mr_a = 8'hFF;
        #1;
        check_val("bp_sr_refill", sr_a, 32'h1);
        tick;
        check_val("bp_mv_refill", mv_a, 32'h08);
        check_val("bp_md3_refill", md_a[24 +: 8], 32'h22);
        sv_a = 1'b0;
        tick;
        check_val("bp_idle_mv", mv_a, 32'h0);

        // Same-cycle drain and load on channel 0
        sv_a = 1'b1; ss_a = 3'd0; sd_a = 8'h10;
        tick;
        check_val("dl_mv0_first", mv_a, 32'h01);
        check_val("dl_md0_first", md_a[0 +: 8], 32'h10);
        sd_a = 8'h20;
        #1;
        check_val("dl_sr", sr_a, 32'h1);
        tick;
        check_val("dl_mv0_second", mv_a, 32'h01);
        check_val("dl_md0_second", md_a[0 +: 8], 32'h20);
        sv_a = 1'b0;
        tick;
        check_val("dl_idle_mv", mv_a, 32'h0);

        // Round-robin over 3 channels, all ready
        mr_b = 3'b111;
        for (int i = 0; i < 7; i++) begin
            sv_b = 1'b1; sd_b = 8'(i + 1);
            check_val($sformatf("rr_ptr_%0d", i), rp_b, 32'(i % 3));
            #1;
            check_val($sformatf("rr_sr_%0d", i), sr_b, 32'h1);
            tick;
            check_val($sformatf("rr_mv_%0d", i), mv_b, 32'(3'b001 << (i % 3)));
            check_val($sformatf("rr_md_%0d", i), md_b[(i % 3)*8 +: 8], 32'(i + 1));
        end
        sv_b = 1'b0;
        tick;
        check_val("rr_end_ptr", rp_b, 32'h1);

        // Round-robin stall: channel 1 full and not ready
        mr_b = 3'b101;
        sv_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sd_b = 8'h08 + 8'(i);
            tick;
        end
        check_val("rr_fill_ptr", rp_b, 32'h1);
        check_val("rr_fill_md1", md_b[8 +: 8], 32'h08);
        sd_b = 8'h0B;
        #1;
        check_val("rr_stall_sr", sr_b, 32'h0);
        tick;
        check_val("rr_stall_ptr", rp_b, 32'h1);
        check_val("rr_stall_md1", md_b[8 +: 8], 32'h08);
        mr_b = 3'b111;
        #1;
        check_val("rr_release_sr", sr_b, 32'h1);
        tick;
        check_val("rr_release_ptr", rp_b, 32'h2);
        check_val("rr_release_md1", md_b[8 +: 8], 32'h0B);
        sv_b = 1'b0;
        tick;

        // Out-of-range drop on a 5-channel addressed instance
        mr_c = 5'b11111;
        sv_c = 1'b1; ss_c = 3'd6; sd_c = 8'hFF;
        #1;
        check_val("oor_sr", sr_c, 32'h1);
        tick;
        check_val("oor_err", es_c, 32'h1);
        check_val("oor_cnt1", dc_c, 32'h1);
        check_val("oor_mv", mv_c, 32'h0);
        sv_c = 1'b0;
        tick;
        check_val("oor_err_pulse", es_c, 32'h0);
        check_val("oor_cnt1_hold", dc_c, 32'h1);
        sv_c = 1'b1;
        for (int i = 0; i < 253; i++) tick;
        check_val("oor_cnt254", dc_c, 32'd254);
        for (int i = 0; i < 47; i++) tick;
        check_val("oor_cnt_sat", dc_c, 32'd255);
        check_val("oor_err_busy", es_c, 32'h1);
        check_val("oor_mv_none", mv_c, 32'h0);
        ss_c = 3'd4; sd_c = 8'h5A;
        tick;
        check_val("oor_inrange_mv", mv_c, 32'h10);
        check_val("oor_inrange_md", md_c[32 +: 8], 32'h5A);
        check_val("oor_inrange_err", es_c, 32'h0);
        check_val("oor_cnt_kept", dc_c, 32'd255);
        sv_c = 1'b0;
        tick;

        // Asynchronous reset mid-stream with channels 2 and 5 full
        mr_a = 8'h00;
        sv_a = 1'b1; ss_a = 3'd2; sd_a = 8'h55;
        tick;
        ss_a = 3'd5; sd_a = 8'h66;
        tick;
        sv_a = 1'b0;
        check_val("mid_mv_full", mv_a, 32'h24);
        #3;
        rst_n = 1'b0;
        #1;
        check_val("arst_mv_a", mv_a, 32'h0);
        check_val("arst_md_a_or", {31'd0, |md_a}, 32'h0);
        check_val("arst_rp_b", rp_b, 32'h0);
        check_val("arst_dc_c", dc_c, 32'h0);
        check_val("arst_mv_b", mv_b, 32'h0);
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        check_val("post_rst_mv_a", mv_a, 32'h0);
        check_val("post_rst_sr_a", sr_a, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/demux_stream_1xn.md
Name: demux_stream_1xn

Overview:
Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshakes; successor to the combinational 1x8 bit demux.
- Routes each accepted input beat of DATA_W bits to one of NUM_CH output channels. Each channel has its own one-entry output register, so a stalled channel blocks only beats addressed to it.
- Two routing modes: addressed (per-beat select) and round-robin (internal rotating pointer).
- Sits between a single producer and N independent consumers in the datapath.

Parameters:
DATA_W, 8, payload width in bits (>=1)
NUM_CH, 8, number of output channels (2..256; need not be a power of two)
MODE, 0, 0 = addressed (s_sel chooses channel), 1 = round-robin (s_sel ignored)
SEL_W is derived, not overridable: clog2(NUM_CH).

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input beat valid
s_ready  out  1  block can accept input beat this cycle
s_data  in  DATA_W  input payload
s_sel  in  SEL_W  target channel (MODE=0 only)
m_valid  out  NUM_CH  per-channel output valid
m_ready  in  NUM_CH  per-channel consumer ready
m_data  out  NUM_CH*DATA_W  per-channel payload; channel k occupies bits [k*DATA_W +: DATA_W]
rr_ptr  out  SEL_W  current round-robin target (held 0 when MODE=0)
err_sel  out  1  one-cycle pulse when an out-of-range beat is dropped
drop_cnt  out  8  saturating count of dropped out-of-range beats

Behaviour:
- Reset (async assert, sync release on clk): m_valid=0, m_data=0, rr_ptr=0, err_sel=0, drop_cnt=0. Reset mid-transfer discards all buffered beats, with no partial output.
- Target channel t: MODE=0 -> t=s_sel; MODE=1 -> t=rr_ptr.
- Channel k is free when m_valid[k]=0 or (m_valid[k]=1 and m_ready[k]=1); the second case is drain and refill in the same cycle.
- s_ready is combinational:
  - 1 if t is out of range (t>=NUM_CH);
  - otherwise 1 when channel t is free.
  - s_ready never depends on s_valid.
- Accept = s_valid & s_ready.
- In-range accept to channel t: next cycle m_valid[t]=1 and m_data[t]=s_data. Latency is exactly 1 cycle and throughput is 1 beat/cycle when consumers are ready.
- Channel k drain (m_valid[k]&m_ready[k]) with no simultaneous load: m_valid[k]<=0. m_data[k] keeps its last value (don't-care when invalid).
- Simultaneous drain and load on the same channel: m_valid stays 1 and the new data is loaded.
- While m_valid[k]=1 and m_ready[k]=0, m_data[k] and m_valid[k] hold stable.
- Non-target channels are never modified by an accept; they drain independently every cycle.
- Out-of-range accept (MODE=0, s_sel>=NUM_CH; only possible when NUM_CH is not a power of two):
  - the beat is consumed and dropped, with no m_valid change;
  - err_sel=1 for the next cycle only;
  - drop_cnt increments and saturates at 255.
- Round-robin (MODE=1):
  - rr_ptr advances by 1 on each accept only, wrapping NUM_CH-1 -> 0;
  - rr_ptr holds when no accept occurs, including when s_valid=1 and the target is full (no skipping of busy channels);
  - out-of-range cannot occur.
- MODE=0: rr_ptr constant 0, and s_sel must be stable while s_valid=1 and s_ready=0.
- Producer rule, for checking only: s_data and s_sel held while s_valid & !s_ready.

Test Plan:
- Reset: drive rst_n=0 mid-stream with channels 2 and 5 full -> all m_valid=0, rr_ptr=0, drop_cnt=0 asynchronously, before the next clk edge.
- Addressed streaming: MODE=0, all m_ready=1, send s_sel=0..7 with data 0xA0..0xA7 back-to-back -> s_ready=1 every cycle; m_valid[k] pulses exactly one cycle, one cycle after accept, with m_data[k]=0xA0+k.
- Backpressure isolation: m_ready[3]=0, send 0x11 to ch3 and then 0x22 to ch3 -> first accepted; second sees s_ready=0 and m_data[3] holds 0x11. Switch s_sel to 1 with 0x33 -> accepted, m_valid[1]=1 next cycle. Raise m_ready[3] -> 0x11 drains and 0x22 is accepted that same cycle.
- Round-robin: MODE=1, NUM_CH=3, 7 beats 0x01..0x07, all ready -> channels receive in order 0,1,2,0,1,2,0 and rr_ptr ends at 1. Hold m_ready[1]=0 with ch1 full -> s_ready=0 and rr_ptr stays 1.
- Out-of-range: MODE=0, NUM_CH=5, s_sel=6, data 0xFF -> s_ready=1, no m_valid change, err_sel high for one cycle, drop_cnt=1. Send 300 such beats -> drop_cnt saturates at 255.
- Same-cycle drain+load: ch0 full (0x10), m_ready[0]=1, accept 0x20 to ch0 -> m_valid[0] stays 1 and m_data[0]=0x20 next cycle, with no bubble.
